// File: rtl/sporta_pkg.sv
// Shared field offsets, slot numbers and types for the serial-port frame demux.
package sporta_pkg;

  localparam int D_LSB   = 0;
  localparam int D_W     = 8;
  localparam int C3Z_BIT = 8;
  localparam int C4_LSB  = 9;
  localparam int C4_W    = 4;
  localparam int C5Z_BIT = 13;
  localparam int C6_LSB  = 14;
  localparam int C6_W    = 2;

  localparam logic [3:0] SLOT_SNAP_START = 4'd1;
  localparam logic [3:0] SLOT_ADC1_BASE  = 4'd2;
  localparam logic [3:0] SLOT_ADC2       = 4'd10;

  localparam int ADC1_W = 14;
  localparam int ADC2_W = 24;

  localparam logic [7:0] IDLE_BYTE = 8'h80;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ARMED,
    ST_CAPTURE,
    ST_DONE
  } snap_state_t;

endpackage

// File: rtl/sporta_snap_buf.sv
// Snapshot byte buffer: append-only write pointer, overflow detect and gated read mux.
module sporta_snap_buf
  import sporta_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          wr_en,
  input  logic [7:0]    wr_data,
  input  logic [AW-1:0] rd_addr,
  input  logic          ready,
  output logic [AW:0]   count,
  output logic          ovf_hit,
  output logic [7:0]    rd_data
);

  localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

  logic [7:0]  mem [DEPTH];
  logic [AW:0] count_reg;
  logic        full;

  assign full    = (count_reg == FULL_COUNT);
  assign ovf_hit = wr_en && full;

  // Contents are don't-care after reset, so the array carries no reset.
  always_ff @(posedge clk) begin
    if (wr_en && !full) begin
      mem[count_reg[AW-1:0]] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_reg <= '0;
    end else if (clr) begin
      count_reg <= '0;
    end else if (wr_en && !full) begin
      count_reg <= count_reg + 1'b1;
    end
  end

  assign count   = count_reg;
  assign rd_data = ready ? mem[rd_addr] : IDLE_BYTE;

endmodule

// File: rtl/sporta_demux_gen.sv
// Demultiplexes the 16-bit frame stream into slow/fast ADC samples and a
// multi-frame raw-byte snapshot for host readout.
module sporta_demux_gen
  import sporta_pkg::*;
#(
  parameter int N_CH1      = 8,
  parameter int N_CH2      = 4,
  parameter int SNAP_DEPTH = 16,
  parameter int SNAP_AW    = $clog2(SNAP_DEPTH)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [15:0]        stream,
  input  logic               stream_tick,
  output logic [ADC1_W-1:0]  adc1_data,
  output logic [N_CH1-1:0]   adc1_gate,
  output logic [ADC2_W-1:0]  adc2_data,
  output logic [N_CH2-1:0]   adc2_gate,
  input  logic               oaddr_sync,
  input  logic [3:0]         snap_frames,
  input  logic [SNAP_AW-1:0] oaddr,
  output logic [7:0]         fifo_out,
  output logic               snap_ready,
  output logic [SNAP_AW:0]   snap_count,
  output logic               frame_err,
  output logic               snap_ovf,
  input  logic               err_clr
);

  localparam logic [3:0] ADC1_LAST = 4'(int'(SLOT_ADC1_BASE) + N_CH1 - 1);

  logic [D_W-1:0]  d;
  logic            c3z;
  logic            c5z;
  logic [C4_W-1:0] c4;
  logic [C6_W-1:0] c6;

  assign d   = stream[D_LSB +: D_W];
  assign c3z = stream[C3Z_BIT];
  assign c4  = stream[C4_LSB +: C4_W];
  assign c5z = stream[C5Z_BIT];
  assign c6  = stream[C6_LSB +: C6_W];

  logic [3:0]        c3_reg;
  logic [3:0]        c3_cur;
  logic [7:0]        lastd1_reg;
  logic [6:0]        lastd2_reg;
  logic [ADC1_W-1:0] adc1_data_reg;
  logic [ADC2_W-1:0] adc2_data_reg;
  logic [N_CH1-1:0]  adc1_gate_reg, adc1_gate_next;
  logic [N_CH2-1:0]  adc2_gate_reg, adc2_gate_next;
  logic              frame_err_reg, snap_ovf_reg;
  logic              in_adc1, adc1_hit, adc2_hit;

  // c3_cur is the byte index of the word currently on the stream.
  assign c3_cur   = c3z ? 4'd0 : ((c3_reg == 4'hF) ? 4'hF : c3_reg + 4'd1);
  assign in_adc1  = (c4 >= SLOT_ADC1_BASE) && (c4 <= ADC1_LAST);
  assign adc1_hit = stream_tick && (c3_cur == 4'd1) && in_adc1;
  assign adc2_hit = stream_tick && c5z && (c3_cur == 4'd3) && (c4 == SLOT_ADC2)
                    && ({1'b0, c6} < 3'(N_CH2));

  genvar gi;
  generate
    for (gi = 0; gi < N_CH1; gi++) begin : g_adc1_gate
      assign adc1_gate_next[gi] = adc1_hit && (c4 == 4'(int'(SLOT_ADC1_BASE) + gi));
    end
    for (gi = 0; gi < N_CH2; gi++) begin : g_adc2_gate
      assign adc2_gate_next[gi] = adc2_hit && (c6 == 2'(gi));
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      c3_reg        <= '0;
      lastd1_reg    <= '0;
      lastd2_reg    <= '0;
      adc1_data_reg <= '0;
      adc2_data_reg <= '0;
      adc1_gate_reg <= '0;
      adc2_gate_reg <= '0;
      frame_err_reg <= 1'b0;
    end else begin
      adc1_gate_reg <= adc1_gate_next;
      adc2_gate_reg <= adc2_gate_next;
      if (stream_tick) begin
        c3_reg     <= c3_cur;
        lastd1_reg <= d;
        lastd2_reg <= lastd1_reg[6:0];
      end
      if (adc1_hit) adc1_data_reg <= {lastd1_reg[6:0], d[7:1]};
      if (adc2_hit) adc2_data_reg <= {lastd2_reg, lastd1_reg, d, 1'b0};
      if (err_clr) begin
        frame_err_reg <= 1'b0;
      end else if (stream_tick && !c3z && (c3_reg == 4'hF)) begin
        frame_err_reg <= 1'b1;
      end
    end
  end

  // Two-flop synchroniser plus a history flop for falling-edge detection.
  logic [2:0] sync_reg;
  logic       arm;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_reg <= 3'b111;
    else        sync_reg <= {sync_reg[1:0], oaddr_sync};
  end

  assign arm = sync_reg[2] && !sync_reg[1];

  snap_state_t state_reg, state_next;
  logic [3:0]  frames_left_reg, frames_left_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg       <= ST_IDLE;
      frames_left_reg <= '0;
    end else begin
      state_reg       <= state_next;
      frames_left_reg <= frames_left_next;
    end
  end

  always_comb begin
    state_next       = state_reg;
    frames_left_next = frames_left_reg;
    if (arm) begin
      state_next       = ST_ARMED;
      frames_left_next = (snap_frames == 4'd0) ? 4'd1 : snap_frames;
    end else begin
      case (state_reg)
        ST_ARMED: begin
          if (stream_tick && (c4 == SLOT_SNAP_START)) state_next = ST_CAPTURE;
        end
        ST_CAPTURE: begin
          if (stream_tick && (c4 == SLOT_ADC2)) begin
            frames_left_next = frames_left_reg - 4'd1;
            if (frames_left_reg == 4'd1) state_next = ST_DONE;
          end
        end
        default: ;
      endcase
    end
  end

  logic cap_en, ovf_hit;

  assign cap_en     = (state_reg == ST_CAPTURE) && !arm && stream_tick
                      && (c3_cur <= 4'd1) && in_adc1;
  assign snap_ready = (state_reg == ST_DONE);

  sporta_snap_buf #(
    .DEPTH (SNAP_DEPTH),
    .AW    (SNAP_AW)
  ) u_snap_buf (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (arm),
    .wr_en   (cap_en),
    .wr_data (d),
    .rd_addr (oaddr),
    .ready   (snap_ready),
    .count   (snap_count),
    .ovf_hit (ovf_hit),
    .rd_data (fifo_out)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       snap_ovf_reg <= 1'b0;
    else if (err_clr) snap_ovf_reg <= 1'b0;
    else if (ovf_hit) snap_ovf_reg <= 1'b1;
  end

  assign adc1_data = adc1_data_reg;
  assign adc2_data = adc2_data_reg;
  assign adc1_gate = adc1_gate_reg;
  assign adc2_gate = adc2_gate_reg;
  assign frame_err = frame_err_reg;
  assign snap_ovf  = snap_ovf_reg;

endmodule
